sum_seq_controller: RTL



---
 rtl/counter_pkg.sv | 28 ++
 rtl/sum_seq_controller.sv | 92 +++++++++
 2 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the A/Sum accumulate datapath and its sequencing controller.
package counter_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_ADD   = 3'd3;
  localparam logic [2:0] ST_INC   = 3'd4;
  localparam logic [2:0] ST_OUT   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    INIT  = ST_INIT,
    CHECK = ST_CHECK,
    ADD   = ST_ADD,
    INC   = ST_INC,
    OUT   = ST_OUT,
    DONE  = ST_DONE
  } state_t;

  localparam logic SEL_ZERO = 1'b0;
  localparam logic SEL_INC  = 1'b1;

  // Loop bound shared by the datapath comparator (A < A_LIMIT).
  localparam int A_LIMIT = 10;

endpackage

// File: rtl/sum_seq_controller.sv
// Moore FSM sequencing the A/Sum datapath: clear, compare, Sum+=A, A+=1, publish, repeat.
// Handshake: start is accepted only in IDLE when abort is low; busy is high in every
// other state; done pulses for one cycle in DONE. abort returns to IDLE from any state.
module sum_seq_controller
  import counter_pkg::*;
#(
  parameter bit TICK_GATE = 1'b1,
  parameter int RUN_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 tick,
  input  logic                 auto_repeat,
  input  logic                 ALt10,
  output logic                 ASrcMuxSel,
  output logic                 SumSrcMuxSel,
  output logic                 ALoad,
  output logic                 SumLoad,
  output logic                 OutPort,
  output logic                 busy,
  output logic                 done,
  output logic [RUN_CNT_W-1:0] run_count
);

  state_t state;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      run_count <= '0;
    end else begin
      state <= state_next;
      // A run only counts once DONE is left normally; aborting out of DONE discards it.
      if (state == DONE && !abort) begin
        run_count <= run_count + RUN_CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    if (abort && state != IDLE) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:  if (start && !abort) state_next = INIT;
        INIT:  state_next = CHECK;
        CHECK: begin
          if (!(TICK_GATE && !tick)) begin
            state_next = ALt10 ? ADD : DONE;
          end
        end
        ADD:   state_next = INC;
        INC:   state_next = OUT;
        OUT:   state_next = CHECK;
        DONE:  state_next = auto_repeat ? INIT : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    ASrcMuxSel   = SEL_ZERO;
    SumSrcMuxSel = SEL_ZERO;
    ALoad        = 1'b0;
    SumLoad      = 1'b0;
    OutPort      = 1'b0;
    done         = 1'b0;
    busy         = (state != IDLE);
    case (state)
      INIT: begin
        ALoad   = 1'b1;
        SumLoad = 1'b1;
      end
      ADD: begin
        SumSrcMuxSel = SEL_INC;
        SumLoad      = 1'b1;
      end
      INC: begin
        ASrcMuxSel = SEL_INC;
        ALoad      = 1'b1;
      end
      OUT:  OutPort = 1'b1;
      DONE: done    = 1'b1;
      default: ;
    endcase
  end

endmodule
